// File: rtl/sio_pkg.sv
// Shared constants and types for the serial I/O host: frame geometry,
// command word layout and the transmit-phase decode.
package sio_pkg;

    localparam int SIO_PERIOD    = 128;
    localparam int SIO_CMD_BITS  = 20;
    localparam int SIO_ADC_BYTES = 24;
    localparam int SIO_RD_BYTES  = 2;
    localparam int SIO_ADDR_W    = 4;
    localparam int SIO_DATA_W    = 16;

    localparam logic [SIO_ADDR_W-1:0] SIO_NOP_ADDR = 4'hF;

    typedef struct packed {
        logic [SIO_ADDR_W-1:0] addr;
        logic [SIO_DATA_W-1:0] wdata;
    } cmd_t;

    localparam cmd_t SIO_NOP_CMD = cmd_t'({SIO_NOP_ADDR, 16'h0000});

    typedef enum logic [2:0] {
        PH_OFF,
        PH_START,
        PH_CMD,
        PH_TURN,
        PH_GUARD
    } phase_e;

endpackage

// File: rtl/sio_host_if.sv
// Command channel into the serial I/O host: valid/ready handshake carrying
// a register address and write data.
interface sio_host_if;
    import sio_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [SIO_ADDR_W-1:0] cmd_addr;
    logic [SIO_DATA_W-1:0] cmd_wdata;

    modport master (output cmd_valid, output cmd_addr, output cmd_wdata, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_addr, input cmd_wdata, output cmd_ready);
endinterface

// File: rtl/sio_rx_deser.sv
// Receive deserialiser: packs sampled DDR pairs MSB first into bytes, strobes
// the ADC bytes and assembles the trailing two bytes into the readback word.
module sio_rx_deser
    import sio_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  frame_start,
    input  logic                  sample_en,
    input  logic [1:0]            sdi,
    input  logic [SIO_ADDR_W-1:0] frame_addr,
    output logic [7:0]            adc_data,
    output logic [4:0]            adc_index,
    output logic                  adc_valid,
    output logic [15:0]           rdata,
    output logic [SIO_ADDR_W-1:0] rdata_addr,
    output logic                  rdata_valid
);

    localparam logic [4:0] IDX_RD_HI = 5'(SIO_ADC_BYTES);
    localparam logic [4:0] IDX_RD_LO = 5'(SIO_ADC_BYTES + SIO_RD_BYTES - 1);

    logic [6:0]            pair_cnt_reg;
    logic [5:0]            shift_reg;
    logic [7:0]            rd_hi_reg;
    logic [7:0]            adc_data_reg;
    logic [4:0]            adc_index_reg;
    logic                  adc_valid_reg;
    logic [15:0]           rdata_reg;
    logic [SIO_ADDR_W-1:0] rdata_addr_reg;
    logic                  rdata_valid_reg;

    logic [6:0] pair_idx;
    logic [7:0] byte_next;
    logic [4:0] byte_idx;

    // A sample in the frame-start cycle itself counts as pair 0.
    always_comb begin
        pair_idx  = frame_start ? 7'd0 : pair_cnt_reg;
        byte_next = {shift_reg, sdi};
        byte_idx  = pair_idx[6:2];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pair_cnt_reg    <= '0;
            shift_reg       <= '0;
            rd_hi_reg       <= '0;
            adc_data_reg    <= '0;
            adc_index_reg   <= '0;
            adc_valid_reg   <= 1'b0;
            rdata_reg       <= '0;
            rdata_addr_reg  <= '0;
            rdata_valid_reg <= 1'b0;
        end else begin
            adc_valid_reg   <= 1'b0;
            rdata_valid_reg <= 1'b0;
            if (sample_en) begin
                shift_reg    <= byte_next[5:0];
                pair_cnt_reg <= pair_idx + 7'd1;
                if (pair_idx[1:0] == 2'd3) begin
                    if (byte_idx < IDX_RD_HI) begin
                        adc_data_reg  <= byte_next;
                        adc_index_reg <= byte_idx;
                        adc_valid_reg <= 1'b1;
                    end else if (byte_idx == IDX_RD_HI) begin
                        rd_hi_reg <= byte_next;
                    end else if (byte_idx == IDX_RD_LO) begin
                        rdata_reg       <= {rd_hi_reg, byte_next};
                        rdata_addr_reg  <= frame_addr;
                        rdata_valid_reg <= 1'b1;
                    end
                end
            end else if (frame_start) begin
                pair_cnt_reg <= '0;
            end
        end
    end

    assign adc_data    = adc_data_reg;
    assign adc_index   = adc_index_reg;
    assign adc_valid   = adc_valid_reg;
    assign rdata       = rdata_reg;
    assign rdata_addr  = rdata_addr_reg;
    assign rdata_valid = rdata_valid_reg;

endmodule

// File: rtl/sio_host.sv
// Serial I/O host: frames a 20-bit command out over a DDR pad pair, then
// turns the line around to receive 24 ADC bytes plus a readback word.
// Optional trailing guard-window check enabled by macro SIO_HOST_GUARD_EN.
module sio_host
    import sio_pkg::*;
#(
    parameter int PERIOD   = SIO_PERIOD,
    parameter int RX_DELAY = 15
) (
    input  logic                  clock,
    input  logic                  reset_n,
    sio_host_if.slave             cmd,
    output logic [1:0]            sdo,
    output logic                  sdo_oe,
    input  logic [1:0]            sdi,
    output logic [7:0]            adc_data,
    output logic [4:0]            adc_index,
    output logic                  adc_valid,
    output logic [15:0]           rdata,
    output logic [SIO_ADDR_W-1:0] rdata_addr,
    output logic                  rdata_valid,
    output logic                  link_error
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [CW-1:0] TX_LAST   = CW'(SIO_CMD_BITS / 2);
    localparam logic [CW-1:0] RX_FIRST  = CW'(RX_DELAY);
    localparam logic [CW-1:0] RX_LAST   = CW'(RX_DELAY + 103);
    localparam logic [CW-1:0] TURN_LAST = CW'(RX_DELAY + 105);

    logic                    run_reg;
    logic [CW-1:0]           count_reg;
    logic                    hold_valid_reg;
    cmd_t                    hold_reg;
    logic [SIO_CMD_BITS-1:0] tx_shift_reg;
    logic [SIO_ADDR_W-1:0]   tx_addr_reg;

    phase_e phase;
    cmd_t   tx_load;
    logic   accept;
    logic   frame_start;
    logic   sample_en;

    assign cmd.cmd_ready = run_reg && !hold_valid_reg;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign frame_start   = run_reg && (count_reg == '0);
    assign sample_en     = run_reg && (count_reg >= RX_FIRST) && (count_reg <= RX_LAST);
    assign tx_load       = hold_valid_reg ? hold_reg : SIO_NOP_CMD;

    always_comb begin
        phase = PH_GUARD;
        if (!run_reg)                   phase = PH_OFF;
        else if (count_reg == '0)       phase = PH_START;
        else if (count_reg <= TX_LAST)  phase = PH_CMD;
        else if (count_reg <= TURN_LAST) phase = PH_TURN;
    end

    // Idle and turnaround park the pad at 2'b11; the target drives during TURN.
    always_comb begin
        sdo    = 2'b11;
        sdo_oe = 1'b0;
        case (phase)
            PH_START: begin
                sdo    = 2'b01;
                sdo_oe = 1'b1;
            end
            PH_CMD: begin
                sdo    = tx_shift_reg[SIO_CMD_BITS-1 -: 2];
                sdo_oe = 1'b1;
            end
            PH_GUARD: sdo_oe = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_reg        <= 1'b0;
            count_reg      <= '0;
            hold_valid_reg <= 1'b0;
            hold_reg       <= '0;
            tx_shift_reg   <= '0;
            tx_addr_reg    <= '0;
        end else begin
            run_reg <= 1'b1;
            if (run_reg) begin
                count_reg <= (count_reg == CNT_LAST) ? '0 : count_reg + 1'b1;
            end
            if (frame_start) begin
                tx_shift_reg <= tx_load;
                tx_addr_reg  <= tx_load.addr;
            end else if (phase == PH_CMD) begin
                tx_shift_reg <= {tx_shift_reg[SIO_CMD_BITS-3:0], 2'b00};
            end
            // An accept in the frame-start cycle lands after the load and waits a frame.
            if (accept) begin
                hold_reg       <= '{addr: cmd.cmd_addr, wdata: cmd.cmd_wdata};
                hold_valid_reg <= 1'b1;
            end else if (frame_start) begin
                hold_valid_reg <= 1'b0;
            end
        end
    end

    sio_rx_deser u_rx (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .sample_en   (sample_en),
        .sdi         (sdi),
        .frame_addr  (tx_addr_reg),
        .adc_data    (adc_data),
        .adc_index   (adc_index),
        .adc_valid   (adc_valid),
        .rdata       (rdata),
        .rdata_addr  (rdata_addr),
        .rdata_valid (rdata_valid)
    );

`ifdef SIO_HOST_GUARD_EN
    logic link_error_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            link_error_reg <= 1'b0;
        end else if (phase == PH_GUARD && sdi != 2'b11) begin
            link_error_reg <= 1'b1;
        end
    end

    assign link_error = link_error_reg;
`else
    assign link_error = 1'b0;
`endif

endmodule

// File: tb/tb_sio_host.sv
// Directed bench for sio_host: command framing, ADC/readback capture,
// handshake back-pressure, mid-frame reset and the guard-window flag.
module tb_sio_host;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  sdo;
    logic        sdo_oe;
    logic [1:0]  sdi = 2'b11;
    logic [7:0]  adc_data;
    logic [4:0]  adc_index;
    logic        adc_valid;
    logic [15:0] rdata;
    logic [3:0]  rdata_addr;
    logic        rdata_valid;
    logic        link_error;

    sio_host_if bus ();

    sio_host #(.PERIOD(128), .RX_DELAY(15)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cmd         (bus.slave),
        .sdo         (sdo),
        .sdo_oe      (sdo_oe),
        .sdi         (sdi),
        .adc_data    (adc_data),
        .adc_index   (adc_index),
        .adc_valid   (adc_valid),
        .rdata       (rdata),
        .rdata_addr  (rdata_addr),
        .rdata_valid (rdata_valid),
        .link_error  (link_error)
    );

    always #16 clock = ~clock;

`ifdef SIO_HOST_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [19:0] offer_q[$];
    logic        m_full = 1'b0;
    logic [7:0]  m_adc_data = '0;
    logic [4:0]  m_adc_idx = '0;
    logic [15:0] m_rdata = '0;
    logic [3:0]  m_raddr = '0;
    logic        m_link = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        offer_q.delete();
        m_full = 1'b0; m_adc_data = '0; m_adc_idx = '0;
        m_rdata = '0; m_raddr = '0; m_link = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sdo"},    32'(sdo), 32'h3);
        chk({tag, "_oe"},     32'(sdo_oe), 32'h0);
        chk({tag, "_ready"},  32'(bus.cmd_ready), 32'h0);
        chk({tag, "_av"},     32'(adc_valid), 32'h0);
        chk({tag, "_rv"},     32'(rdata_valid), 32'h0);
        chk({tag, "_adata"},  32'(adc_data), 32'h0);
        chk({tag, "_aidx"},   32'(adc_index), 32'h0);
        chk({tag, "_rdata"},  32'(rdata), 32'h0);
        chk({tag, "_raddr"},  32'(rdata_addr), 32'h0);
        chk({tag, "_link"},   32'(link_error), 32'h0);
    endtask

    // One frame (or its first ncyc counts) with a target model on sdi.
    task automatic run_frame(input logic [19:0] word, input logic [3:0] raddr,
                             input logic [7:0] seed, input logic [15:0] rword,
                             input int ncyc, input int push_at,
                             input logic [19:0] w0, input logic [19:0] w1,
                             input int npush, input int poke_at);
        for (int c = 0; c < ncyc; c++) begin
            logic [7:0] tbyte;
            logic       acc;
            int         k;
            int         b;
            @(negedge clock);
            if (c == push_at) begin
                offer_q.push_back(w0);
                if (npush > 1) offer_q.push_back(w1);
            end
            if (offer_q.size() > 0) begin
                bus.cmd_valid = 1'b1;
                {bus.cmd_addr, bus.cmd_wdata} = offer_q[0];
            end else begin
                bus.cmd_valid = 1'b0;
            end
            sdi = 2'b11;
            if (c >= 15 && c <= 118) begin
                k = c - 15;
                b = k / 4;
                if (b < 24)       tbyte = 8'(b) ^ seed;
                else if (b == 24) tbyte = rword[15:8];
                else              tbyte = rword[7:0];
                sdi = 2'((tbyte >> (6 - 2 * (k % 4))) & 8'h3);
            end
            if (c == poke_at) sdi = 2'b10;

            chk("sdo_oe", 32'(sdo_oe), (c <= 10 || c >= 121) ? 32'h1 : 32'h0);
            if (c == 0)
                chk("sdo_start", 32'(sdo), 32'h1);
            else if (c <= 10)
                chk("sdo_bits", 32'(sdo), 32'((word >> (20 - 2 * c)) & 20'h3));
            else if (c >= 121)
                chk("sdo_idle", 32'(sdo), 32'h3);

            if (c >= 19 && c <= 111 && ((c - 19) % 4 == 0)) begin
                m_adc_idx  = 5'((c - 19) / 4);
                m_adc_data = 8'((c - 19) / 4) ^ seed;
                chk("adc_valid", 32'(adc_valid), 32'h1);
            end else begin
                chk("adc_valid", 32'(adc_valid), 32'h0);
            end
            chk("adc_data",  32'(adc_data), 32'(m_adc_data));
            chk("adc_index", 32'(adc_index), 32'(m_adc_idx));

            if (c == 119) begin
                m_rdata = rword;
                m_raddr = raddr;
            end
            chk("rdata_valid", 32'(rdata_valid), (c == 119) ? 32'h1 : 32'h0);
            chk("rdata",       32'(rdata), 32'(m_rdata));
            chk("rdata_addr",  32'(rdata_addr), 32'(m_raddr));
            chk("cmd_ready",   32'(bus.cmd_ready), 32'(!m_full));
            chk("link_error",  32'(link_error), 32'(m_link));

            acc = bus.cmd_valid && !m_full;
            if (acc) void'(offer_q.pop_front());
            m_full = acc ? 1'b1 : ((c == 0) ? 1'b0 : m_full);
            if (GUARD && c >= 121 && sdi != 2'b11) m_link = 1'b1;
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        repeat (3) @(negedge clock);
        check_reset_outputs("rst");
        reset_n = 1'b1;

        // NOP frame with CAFE readback; queue addr 1 mid-frame.
        run_frame(20'hF0000, 4'hF, 8'h00, 16'hCAFE, 128, 40, 20'h10040, 20'h0, 1, -1);
        // Command frame; two back-to-back commands offered, second must stall.
        run_frame(20'h10040, 4'h1, 8'h5A, 16'h1234, 128, 50, 20'h2AAAA, 20'h35555, 2, -1);
        run_frame(20'h2AAAA, 4'h2, 8'hA5, 16'h8001, 128, -1, 20'h0, 20'h0, 0, -1);
        run_frame(20'h35555, 4'h3, 8'h3C, 16'h7E00, 128, -1, 20'h0, 20'h0, 0, -1);

        // Abort a NOP frame at count 60.
        run_frame(20'hF0000, 4'hF, 8'h11, 16'h0F0F, 60, -1, 20'h0, 20'h0, 0, -1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("abort_oe", 32'(sdo_oe), 32'h0);
        chk("abort_sdo", 32'(sdo), 32'h3);
        repeat (2) @(negedge clock);
        check_reset_outputs("abort");
        reset_model();
        reset_n = 1'b1;

        // Fresh NOP frame after release, with a guard-window violation at 125.
        run_frame(20'hF0000, 4'hF, 8'hC3, 16'hBEEF, 128, -1, 20'h0, 20'h0, 0, 125);
        @(negedge clock);
        chk("link_sticky", 32'(link_error), GUARD ? 32'h1 : 32'h0);
        reset_n = 1'b0;
        #1;
        chk("link_cleared", 32'(link_error), 32'h0);
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sio_host.md
SIO_HOST -- requirements
Module: sio_host

Interface
REQ-001 Parameter PERIOD, default 128, clocks per frame; SHALL be >= RX_DELAY+107.
REQ-002 Parameter RX_DELAY, default 15, frame count at which the first received bit pair is sampled.
REQ-003 clock  input  1  sole clock, 31.25 MHz; everything SHALL be synchronous to it.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command holding register empty.
REQ-007 cmd_addr  input  4  target register address.
REQ-008 cmd_wdata  input  16  target write data.
REQ-009 sdo  output  2  DDR pair to pad; sdo[1] is the first half-cycle bit.
REQ-010 sdo_oe  output  1  pad output enable.
REQ-011 sdi  input  2  DDR pair from pad; sdi[1] is the first half-cycle bit.
REQ-012 adc_data  output  8  received ADC byte.
REQ-013 adc_index  output  5  byte index 0..23 within frame.
REQ-014 adc_valid  output  1  one-clock strobe qualifying adc_data/adc_index.
REQ-015 rdata  output  16  readback word.
REQ-016 rdata_addr  output  4  address of the command that produced rdata.
REQ-017 rdata_valid  output  1  one-clock strobe qualifying rdata/rdata_addr.
REQ-018 link_error  output  1  sticky guard-window error (see Configuration).

Function
REQ-019 Frame counter SHALL run 0..PERIOD-1 and wrap to 0 without gaps.
REQ-020 Handshake: cmd_ready = holding register empty; transfer on cmd_valid&&cmd_ready; cmd_ready SHALL drop the clock after transfer.
REQ-021 At count 0, the 20-bit word {addr,wdata} SHALL be loaded from the holding register (which then empties) or, if empty, NOP {4'hF,16'h0000}; a command accepted in the count-0 cycle itself SHALL go in the next frame.
REQ-022 Count 0: sdo=2'b01, sdo_oe=1 (start marker, sdo[1]=0).
REQ-023 Counts 1..10: sdo = next two word bits MSB first (count 1 carries bits 19:18, count 10 bits 1:0), sdo_oe=1.
REQ-024 Counts 11..RX_DELAY+105: sdo_oe=0 (target owns line); all other counts: sdo=2'b11, sdo_oe=1.
REQ-025 Pair k (0..103) SHALL be sampled at count RX_DELAY+k, shifted in sdi[1] then sdi[0], MSB first, four pairs per byte.
REQ-026 Bytes 0..23 SHALL appear on adc_data with adc_index=byte number and adc_valid high at count RX_DELAY+4*b+4.
REQ-027 Bytes 24,25 SHALL form rdata {byte24,byte25}, with rdata_addr = this frame's sent address; rdata_valid high at count RX_DELAY+104.
REQ-028 NOP frames SHALL still produce all 24 adc_valid strobes and one rdata_valid.
REQ-029 adc_data, adc_index, rdata, rdata_addr SHALL hold between strobes.

Reset
REQ-030 While reset_n low: count=0, holding register empty, cmd_ready=0, sdo=2'b11, sdo_oe=0, all strobes 0, data outputs 0, link_error 0.
REQ-031 First clock after release: cmd_ready=1 and frame count 0 begins (NOP start marker).
REQ-032 Reset mid-frame SHALL abort it; no partial strobes after release.

Configuration
REQ-033 Macro SIO_HOST_GUARD_EN defined: counts RX_DELAY+106..PERIOD-1 sample sdi; any value != 2'b11 sets link_error, cleared only by reset.
REQ-034 Macro undefined: no guard logic; link_error tied 0.

Structure
REQ-035 Package sio_pkg SHALL hold SIO_PERIOD=128, SIO_NOP_ADDR=4'hF, SIO_CMD_BITS=20, SIO_ADC_BYTES=24, SIO_RD_BYTES=2.
REQ-036 Sub-module sio_rx_deser SHALL do pair-to-byte shifting and byte counting; framing/TX stays in sio_host.

Verification
REQ-037 Command {4'h1,16'h0040} queued before count 0 -> count 0 sdo=01, counts 1..10 sdo=00,01,00,00,00,00,00,01,00,00; cmd_ready 1 after count 0.
REQ-038 No command pending -> transmitted word 20'hF0000; rdata_addr=4'hF.
REQ-039 Target model drives bytes 0x00..0x17 then 0xCA,0xFE -> 24 adc_valid strobes, index 0..23 with matching data; rdata=16'hCAFE at count 119 (RX_DELAY=15).
REQ-040 Two back-to-back commands (addr 2 then 3) -> second stalls (cmd_ready=0) until first frame count 0, each sent in consecutive frames.
REQ-041 reset_n pulled low at count 60 -> sdo_oe=0 immediately, no strobes; after release new frame starts at count 0 with NOP.
REQ-042 SIO_HOST_GUARD_EN defined, sdi forced 2'b10 at count 125 -> link_error=1 until reset; undefined -> link_error stays 0.
